// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants for the 1x3 router blocks
package router_pkg;

  localparam int DATA_WIDTH = 8;

  // Address field of the header byte; address 3 selects no output port.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam logic [ADDR_MSB-ADDR_LSB:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - running byte parity, captured packet parity and mismatch flag
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          xor_en,
  input  logic [DW-1:0] xor_data,
  input  logic          cap_en,
  input  logic [DW-1:0] cap_data,
  input  logic          err_en,
  output logic          err
);

  logic [DW-1:0] int_par_q, int_par_d;
  logic [DW-1:0] pkt_par_q, pkt_par_d;
  logic          err_q, err_d;

  always_comb begin
    int_par_d = int_par_q;
    pkt_par_d = pkt_par_q;
    err_d     = err_q;
    if (clear) begin
      int_par_d = '0;
      err_d     = 1'b0;
    end else begin
      if (xor_en) int_par_d = int_par_q ^ xor_data;
      if (cap_en) pkt_par_d = cap_data;
      // Compares registered values, so err trails parity_done by one cycle.
      if (err_en) err_d = (int_par_q != pkt_par_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_par_q <= '0;
      pkt_par_q <= '0;
      err_q     <= 1'b0;
    end else begin
      int_par_q <= int_par_d;
      pkt_par_q <= pkt_par_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath register stage driven by router_fsm state strobes
module router_reg
  import router_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          pkt_valid,
  input  logic          fifo_full,
  input  logic          rst_int_reg,
  input  logic          detect_add,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          lfd_state,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] hdr_q, hdr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          parity_done_q, parity_done_d;
  logic          low_pkt_valid_q, low_pkt_valid_d;

  logic          lfd_act, ld_act, laf_act, freeze;
  logic          pd_set_ld, pd_set_laf;
  logic          xor_en, cap_en, err_en;
  logic [DW-1:0] xor_data, cap_data;

  always_comb begin
    // Resolve overlapping strobes: detect_add > lfd > ld > laf.
    lfd_act = lfd_state & ~detect_add;
    ld_act  = ld_state & ~detect_add & ~lfd_state;
    laf_act = laf_state & ~detect_add & ~lfd_state & ~ld_state;
    freeze  = full_state & ~(detect_add | lfd_state | ld_state | laf_state);

    hdr_d = hdr_q;
    if (detect_add && pkt_valid && data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID)
      hdr_d = data_in;

    dout_d = dout_q;
    hold_d = hold_q;
    if (lfd_act)
      dout_d = hdr_q;
    else if (ld_act && !fifo_full)
      dout_d = data_in;
    else if (ld_act && fifo_full)
      hold_d = data_in;
    else if (laf_act)
      dout_d = hold_q;

    low_pkt_valid_d = low_pkt_valid_q;
    if (ld_act && !pkt_valid) low_pkt_valid_d = 1'b1;
    if (rst_int_reg) low_pkt_valid_d = 1'b0;

    pd_set_ld  = ld_act & ~fifo_full & ~pkt_valid;
    pd_set_laf = laf_act & low_pkt_valid_q & ~parity_done_q;
    parity_done_d = parity_done_q;
    if (detect_add)
      parity_done_d = 1'b0;
    else if (pd_set_ld || pd_set_laf)
      parity_done_d = 1'b1;

    // The parity byte itself is captured, never accumulated.
    cap_en   = (pd_set_ld | pd_set_laf) & ~parity_done_q;
    cap_data = pd_set_ld ? data_in : hold_q;

    xor_en   = lfd_act | (ld_act & pkt_valid & ~fifo_full) | (laf_act & ~low_pkt_valid_q);
    xor_data = lfd_act ? hdr_q : (ld_act ? data_in : hold_q);

    err_en = parity_done_q & ~detect_add & ~freeze;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q           <= '0;
      hold_q          <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity_acc #(.DW(DW)) u_parity (
    .clk      (clk),
    .rst      (rst),
    .clear    (detect_add),
    .xor_en   (xor_en),
    .xor_data (xor_data),
    .cap_en   (cap_en),
    .cap_data (cap_data),
    .err_en   (err_en),
    .err      (err)
  );

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - self-checking bench for router_reg: directed vector table plus randomized model check
module tb_router_reg;
  import router_pkg::*;

  localparam logic [2:0] S_NONE = 3'd0, S_DA = 3'd1, S_LFD = 3'd2,
                         S_LD = 3'd3, S_LAF = 3'd4, S_FULL = 3'd5;

  logic       clk = 1'b0;
  logic       rst, pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, ld_state, laf_state, full_state, lfd_state;
  logic [7:0] data_in, dout;
  logic       parity_done, low_pkt_valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  router_reg dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .pkt_valid     (pkt_valid),
    .fifo_full     (fifo_full),
    .rst_int_reg   (rst_int_reg),
    .detect_add    (detect_add),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .lfd_state     (lfd_state),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .dout          (dout)
  );

  typedef struct {
    logic       r;
    logic [2:0] st;
    logic [7:0] d;
    logic       pv, ff, ri;
    logic [7:0] e_dout;
    logic       e_pd, e_lpv, e_err;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference state
  logic [7:0] m_hdr, m_hold, m_dout, m_ip, m_pp;
  logic       m_pd, m_lpv, m_err;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_dout,
                           input logic e_pd, input logic e_lpv, input logic e_err);
    check({tag, "_dout"}, dout, e_dout);
    check({tag, "_parity_done"}, {7'd0, parity_done}, {7'd0, e_pd});
    check({tag, "_low_pkt_valid"}, {7'd0, low_pkt_valid}, {7'd0, e_lpv});
    check({tag, "_err"}, {7'd0, err}, {7'd0, e_err});
  endtask

  task automatic drive(input logic r, input logic da, input logic lfd, input logic ld,
                       input logic laf, input logic full, input logic [7:0] d,
                       input logic pv, input logic ff, input logic ri);
    rst = r; detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = full; data_in = d; pkt_valid = pv; fifo_full = ff; rst_int_reg = ri;
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] st, input logic [7:0] d,
                              input logic pv, input logic ff, input logic ri,
                              input logic [7:0] e_dout, input logic e_pd,
                              input logic e_lpv, input logic e_err);
    vec_t v;
    v.r = r; v.st = st; v.d = d; v.pv = pv; v.ff = ff; v.ri = ri;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    return v;
  endfunction

  // Packet-level rules: act is the single strobe that wins after priority.
  task automatic model_step(input logic r, input logic [2:0] act, input logic [7:0] d,
                            input logic pv, input logic ff, input logic ri);
    logic       old_pd, old_lpv;
    logic [7:0] old_ip, old_pp;
    if (r) begin
      m_hdr = 0; m_hold = 0; m_dout = 0; m_ip = 0; m_pp = 0;
      m_pd = 0; m_lpv = 0; m_err = 0;
      return;
    end
    old_pd = m_pd; old_lpv = m_lpv; old_ip = m_ip; old_pp = m_pp;
    case (act)
      S_DA: begin
        if (pv && d[1:0] != ADDR_INVALID) m_hdr = d;
        m_pd = 0; m_ip = 0; m_err = 0;
      end
      S_LFD: begin
        m_dout = m_hdr;
        m_ip   = m_ip ^ m_hdr;
      end
      S_LD: begin
        if (ff) m_hold = d;
        else begin
          m_dout = d;
          if (pv) m_ip = m_ip ^ d;
          else if (!old_pd) begin m_pd = 1; m_pp = d; end
        end
        if (!pv) m_lpv = 1;
      end
      S_LAF: begin
        m_dout = m_hold;
        if (!old_lpv) m_ip = m_ip ^ m_hold;
        else if (!old_pd) begin m_pd = 1; m_pp = m_hold; end
      end
      default: ;
    endcase
    if (old_pd && act != S_DA && act != S_FULL) m_err = (old_ip != old_pp);
    if (ri) m_lpv = 0;
  endtask

  initial begin
    logic [7:0] good_par;
    good_par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;

    // Good packet
    vecs.push_back(mk(0, S_DA,   8'h0D, 1, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, S_LFD,  8'h11, 1, 0, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h11, 1, 0, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h22, 1, 0, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h33, 1, 0, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   good_par, 0, 0, 0, good_par, 1, 1, 0));
    vecs.push_back(mk(0, S_NONE, 8'h00, 0, 0, 1, good_par, 1, 0, 0));
    // Bad parity
    vecs.push_back(mk(0, S_DA,   8'h0D, 1, 0, 0, good_par, 0, 0, 0));
    vecs.push_back(mk(0, S_LFD,  8'h11, 1, 0, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h11, 1, 0, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h22, 1, 0, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h33, 1, 0, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h2C, 0, 0, 0, 8'h2C, 1, 1, 0));
    vecs.push_back(mk(0, S_NONE, 8'h00, 0, 0, 1, 8'h2C, 1, 0, 1));
    vecs.push_back(mk(0, S_NONE, 8'h00, 0, 0, 0, 8'h2C, 1, 0, 1));
    // Full mid-payload; next detect_add clears err
    vecs.push_back(mk(0, S_DA,   8'h0D, 1, 0, 0, 8'h2C, 0, 0, 0));
    vecs.push_back(mk(0, S_LFD,  8'h11, 1, 0, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h11, 1, 0, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h22, 1, 1, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_FULL, 8'h33, 1, 1, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_LAF,  8'h33, 1, 0, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h33, 1, 0, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   good_par, 0, 0, 0, good_par, 1, 1, 0));
    vecs.push_back(mk(0, S_NONE, 8'h00, 0, 0, 1, good_par, 1, 0, 0));
    // Full on the parity byte, completed through laf
    vecs.push_back(mk(0, S_DA,   8'h0D, 1, 0, 0, good_par, 0, 0, 0));
    vecs.push_back(mk(0, S_LFD,  8'h11, 1, 0, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h11, 1, 0, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h22, 1, 0, 0, 8'h22, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h33, 1, 0, 0, 8'h33, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   good_par, 0, 1, 0, 8'h33, 0, 1, 0));
    vecs.push_back(mk(0, S_FULL, 8'h00, 0, 1, 0, 8'h33, 0, 1, 0));
    vecs.push_back(mk(0, S_LAF,  8'h00, 0, 0, 0, good_par, 1, 1, 0));
    vecs.push_back(mk(0, S_NONE, 8'h00, 0, 0, 1, good_par, 1, 0, 0));
    // Address 3 never latched
    vecs.push_back(mk(0, S_DA,   8'h03, 1, 0, 0, good_par, 0, 0, 0));
    vecs.push_back(mk(0, S_LFD,  8'h11, 1, 0, 0, 8'h0D, 0, 0, 0));
    // Reset mid-packet leaves no residue in hold or parity state
    vecs.push_back(mk(0, S_DA,   8'h06, 1, 0, 0, 8'h0D, 0, 0, 0));
    vecs.push_back(mk(0, S_LFD,  8'h11, 1, 0, 0, 8'h06, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h11, 1, 0, 0, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, S_LD,   8'h22, 0, 1, 0, 8'h11, 0, 1, 0));
    vecs.push_back(mk(1, S_LD,   8'h77, 1, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, S_LAF,  8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    // Clear of low_pkt_valid wins over set; err follows one cycle later
    vecs.push_back(mk(0, S_LD,   8'h55, 0, 0, 1, 8'h55, 1, 0, 0));
    vecs.push_back(mk(0, S_NONE, 8'h00, 0, 0, 0, 8'h55, 1, 0, 1));

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
    end
    #1;
    check_all("reset", 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].st == S_DA, vecs[i].st == S_LFD, vecs[i].st == S_LD,
            vecs[i].st == S_LAF, vecs[i].st == S_FULL, vecs[i].d,
            vecs[i].pv, vecs[i].ff, vecs[i].ri);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_pd, vecs[i].e_lpv, vecs[i].e_err);
    end

    // Randomized strobes against the reference model
    drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    model_step(1, S_NONE, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 1500; n++) begin
      logic       r, pv, ff, ri;
      logic [7:0] d;
      logic [2:0] pick, act;
      logic [3:0] bits;
      logic       full;
      r    = ($urandom_range(63) == 0);
      pick = 3'($urandom_range(5));
      bits = 4'b0000;
      full = 1'b0;
      case (pick)
        S_DA:   bits[0] = 1'b1;
        S_LFD:  bits[1] = 1'b1;
        S_LD:   bits[2] = 1'b1;
        S_LAF:  bits[3] = 1'b1;
        S_FULL: full = 1'b1;
        default: ;
      endcase
      if (!full && $urandom_range(9) == 0) bits[$urandom_range(3)] = 1'b1;
      d  = 8'($urandom);
      pv = 1'($urandom);
      ff = ($urandom_range(9) < 3);
      ri = ($urandom_range(7) == 0);
      if (bits[0])      act = S_DA;
      else if (bits[1]) act = S_LFD;
      else if (bits[2]) act = S_LD;
      else if (bits[3]) act = S_LAF;
      else if (full)    act = S_FULL;
      else              act = S_NONE;
      drive(r, bits[0], bits[1], bits[2], bits[3], full, d, pv, ff, ri);
      model_step(r, act, d, pv, ff, ri);
      @(posedge clk);
      #1;
      check_all($sformatf("rand%0d", n), m_dout, m_pd, m_lpv, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
